// File: rtl/vga_mode_loader.sv
// vga_mode_loader: programs the VGA core's four timing/colour registers over a
// Wishbone write-only master, one register per strobe, enable word written last.
// Latency: first strobe the cycle after start; each write is strobe..ack then a
// one-cycle gap; done pulses one cycle after the last gap (12 cycles with a 1-cycle slave).
// Backpressure: the strobe is held with stable address/data until wb_ack_i; a start
// arriving while busy is dropped.
//
// Ports: clk/reset (sync, active-high); start, mode_sel, color request a mode;
// wb_* is the Wishbone master; busy/done/error report sequence status.
// Optional macro VGA_MODE_LOADER_TIMEOUT_EN: abandon a write after TIMEOUT strobe
// cycles without ack, flag error and finish without done.
module vga_mode_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0400_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode_sel,
  input  logic [11:0] color,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, WRITE, GAP, FINISH} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        error_nxt;
  logic        mode_on;     // latched: 1 = 640x480, 0 = blank
  logic [11:0] color_q;
  logic        timed_out;

  wire accept = (state == IDLE) && start;

`ifdef VGA_MODE_LOADER_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Zero whenever the strobe is down, so it restarts on every strobe assertion.
  always_ff @(posedge clk) begin
    if (reset || state != WRITE) tmo_cnt <= '0;
    else if (!wb_ack_i)          tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign timed_out = (state == WRITE) && !wb_ack_i && (tmo_cnt == 8'(TIMEOUT - 1));
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      error   <= 1'b0;
      mode_on <= 1'b0;
      color_q <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      error <= error_nxt;
      if (accept) begin
        mode_on <= (mode_sel == 2'd1);
        color_q <= color;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    error_nxt = error;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          error_nxt = mode_sel[1];  // modes 2/3 are reserved
          state_nxt = mode_sel[1] ? FINISH : WRITE;
        end
      end
      WRITE: begin
        if (wb_ack_i) begin
          state_nxt = GAP;
        end else if (timed_out) begin
          error_nxt = 1'b1;
          state_nxt = FINISH;
        end
      end
      GAP: begin
        if (idx == 2'd3) begin
          state_nxt = FINISH;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = WRITE;
        end
      end
      default: state_nxt = IDLE;  // FINISH
    endcase
  end

  // Mode field values; everything is zero in blank mode.
  logic [9:0] h_sync_start, h_sync_end, h_active_end;
  logic [9:0] v_sync_start, v_sync_end, v_active_end;
  assign h_sync_start = mode_on ? 10'd656 : 10'd0;
  assign h_sync_end   = mode_on ? 10'd752 : 10'd0;
  assign h_active_end = mode_on ? 10'd640 : 10'd0;
  assign v_sync_start = mode_on ? 10'd490 : 10'd0;
  assign v_sync_end   = mode_on ? 10'd492 : 10'd0;
  assign v_active_end = mode_on ? 10'd480 : 10'd0;

  // Outputs decode straight from state so a reset edge drops the strobe at once.
  always_comb begin
    wb_addr_o = '0;
    wb_data_o = '0;
    wb_sel_o  = '0;
    wb_stb_o  = 1'b0;
    if (state == WRITE) begin
      wb_stb_o = 1'b1;
      wb_sel_o = 4'hF;
      // idx2 targets +0xC and idx3 +0x8 so the enable word lands last.
      case (idx)
        2'd0: begin
          wb_addr_o = BASE_ADDR;
          wb_data_o = {2'b0, h_sync_start, h_sync_end, 10'd0};
        end
        2'd1: begin
          wb_addr_o = BASE_ADDR + 32'h4;
          wb_data_o = {2'b0, v_sync_start, v_sync_end, 10'd0};
        end
        2'd2: begin
          wb_addr_o = BASE_ADDR + 32'hC;
          wb_data_o = {20'b0, color_q};
        end
        default: begin
          wb_addr_o = BASE_ADDR + 32'h8;
          wb_data_o = {9'b0, mode_on, mode_on, mode_on, h_active_end, v_active_end};
        end
      endcase
    end
  end

  assign wb_we_o  = wb_stb_o;
  assign wb_cyc_o = wb_stb_o;
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH) && !error;

endmodule

// File: tb/tb_vga_mode_loader.sv
// tb_vga_mode_loader: directed + randomized checks of vga_mode_loader against a
// register-level reference model (field arithmetic, write order, cycle budget)
// and a configurable registered Wishbone slave.
module tb_vga_mode_loader;
  localparam logic [31:0] BASE = 32'h0400_0000;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  mode_sel;
  logic [11:0] color;
  logic [31:0] wb_addr_o, wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
  logic        busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  // slave configuration: ack after slave_lat strobe cycles, held slave_hold cycles
  int slave_lat  = 1;
  int slave_hold = 1;
  bit slave_mute = 1'b0;
  int stb_cnt, ack_left;
  logic stb_s;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always #5 clk = ~clk;

  vga_mode_loader #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_sel(mode_sel), .color(color),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .busy(busy), .done(done), .error(error)
  );

  // strobe sampled mid-cycle, so the slave reacts to the cycle just ended
  always @(negedge clk) stb_s <= wb_stb_o;

  always @(posedge clk) begin
    if (reset) begin
      wb_ack_i <= 1'b0;
      stb_cnt  <= 0;
      ack_left <= 0;
    end else if (ack_left > 0) begin
      wb_ack_i <= 1'b1;
      ack_left <= ack_left - 1;
    end else if (stb_s && !wb_ack_i && !slave_mute) begin
      if (stb_cnt + 1 >= slave_lat) begin
        wb_ack_i <= 1'b1;
        ack_left <= slave_hold - 1;
        stb_cnt  <= 0;
      end else begin
        wb_ack_i <= 1'b0;
        stb_cnt  <= stb_cnt + 1;
      end
    end else begin
      wb_ack_i <= 1'b0;
      stb_cnt  <= 0;
    end
  end

  // a write completes on any edge that sees cyc and ack together
  always @(negedge clk) begin
    if (!reset && wb_cyc_o === 1'b1 && wb_ack_i === 1'b1) begin
      wr_addr_q.push_back(wb_addr_o);
      wr_data_q.push_back(wb_data_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr(input int i);
    case (i)
      0:       return BASE;
      1:       return BASE + 32'd4;
      2:       return BASE + 32'd12;
      default: return BASE + 32'd8;
    endcase
  endfunction

  // register image computed from mode field values with plain arithmetic
  function automatic logic [31:0] exp_word(input int mode, input logic [11:0] col, input int i);
    int hss = 0, hse = 0, has = 0, hae = 0;
    int vss = 0, vse = 0, vas = 0, vae = 0, on = 0;
    if (mode == 1) begin
      hss = 656; hse = 752; hae = 640;
      vss = 490; vse = 492; vae = 480; on = 1;
    end
    case (i)
      0:       return 32'(hss * 1048576 + hse * 1024 + has);
      1:       return 32'(vss * 1048576 + vse * 1024 + vas);
      2:       return {20'b0, col};
      default: return 32'(on * 7 * 1048576 + hae * 1024 + vae);
    endcase
  endfunction

  task automatic run_seq(input int mode, input logic [11:0] col, input int lat, input int hold);
    int k;
    bit seen_done, bad_ctl, bad_hold, bad_busy;
    logic [31:0] pa, pd;
    logic pc;
    slave_lat  = lat;
    slave_hold = hold;
    wr_addr_q.delete();
    wr_data_q.delete();
    mode_sel = 2'(mode);
    color    = col;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    mode_sel = 2'($urandom);
    color    = 12'($urandom);
    chk("first_strobe", wb_cyc_o, 1);
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    k = 0; seen_done = 0; bad_ctl = 0; bad_hold = 0; bad_busy = 0;
    pa = wb_addr_o; pd = wb_data_o; pc = wb_cyc_o;
    while (!seen_done && k < 200) begin
      start = (k == 3);  // must be ignored while busy
      tick();
      k++;
      if (wb_cyc_o !== wb_stb_o || wb_cyc_o !== wb_we_o ||
          wb_sel_o !== (wb_cyc_o ? 4'hF : 4'h0)) bad_ctl = 1;
      if (pc && wb_cyc_o && (wb_addr_o !== pa || wb_data_o !== pd)) bad_hold = 1;
      if (busy !== 1'b1 || error !== 1'b0) bad_busy = 1;
      pa = wb_addr_o; pd = wb_data_o; pc = wb_cyc_o;
      if (done === 1'b1) seen_done = 1;
    end
    start = 1'b0;
    chk("done_seen", 32'(seen_done), 1);
    chk("done_latency", k, 4 * (lat + 2));
    chk("ctl_signals", 32'(bad_ctl), 0);
    chk("strobe_stable", 32'(bad_hold), 0);
    chk("busy_error_during", 32'(bad_busy), 0);
    tick();
    chk("busy_low_after", busy, 0);
    chk("done_one_cycle", done, 0);
    tick();
    tick();
    chk("no_queued_start", wb_cyc_o, 0);
    chk("write_count", wr_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr_q.size()) begin
        chk($sformatf("wr%0d_addr", i), wr_addr_q[i], exp_addr(i));
        chk($sformatf("wr%0d_data", i), wr_data_q[i], exp_word(mode, col, i));
      end
    end
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; mode_sel = 2'd0; color = 12'd0;
    tick(); tick(); tick();
    chk("rst_addr", wb_addr_o, 0);
    chk("rst_data", wb_data_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    tick();

    // reference sequence: 640x480, orange fill, 1-cycle slave
    run_seq(1, 12'hF80, 1, 1);
    // blank mode still issues all four writes
    run_seq(0, 12'($urandom), 1, 1);

    // reserved mode: finish immediately with error, no bus activity
    wr_addr_q.delete();
    mode_sel = 2'd2; color = 12'($urandom); start = 1'b1;
    tick();
    start = 1'b0;
    chk("rsv_busy", busy, 1);
    chk("rsv_cyc", wb_cyc_o, 0);
    chk("rsv_done", done, 0);
    tick();
    chk("rsv_busy_end", busy, 0);
    chk("rsv_error", error, 1);
    chk("rsv_done_end", done, 0);
    tick();
    chk("rsv_error_sticky", error, 1);
    chk("rsv_no_writes", wr_addr_q.size(), 0);
    run_seq(1, 12'($urandom), 1, 1);

    // slave holding ack for two cycles
    run_seq(1, 12'($urandom), 1, 2);
    run_seq(0, 12'($urandom), 2, 2);

    for (int r = 0; r < 4; r++)
      run_seq($urandom_range(0, 1), 12'($urandom), $urandom_range(1, 3), $urandom_range(1, 2));

    // reset while the colour word (idx2) is on the bus
    slave_lat = 1; slave_hold = 1;
    mode_sel = 2'd1; color = 12'($urandom); start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(wb_cyc_o === 1'b1 && wb_addr_o === BASE + 32'd12) && k < 100) begin
      tick();
      k++;
    end
    chk("reach_idx2", 32'(k < 100), 1);
    reset = 1'b1;
    tick();
    chk("midrst_cyc", wb_cyc_o, 0);
    chk("midrst_addr", wb_addr_o, 0);
    chk("midrst_data", wb_data_o, 0);
    chk("midrst_sel", wb_sel_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    tick(); tick();
    chk("midrst_idle", wb_cyc_o, 0);
    run_seq(1, 12'($urandom), 1, 1);

    // silent slave
    slave_mute = 1'b1;
    mode_sel = 2'd1; color = 12'($urandom); start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (wb_cyc_o === 1'b1 && k < 40) begin
      tick();
      if (wb_cyc_o === 1'b1) k++;
    end
`ifdef VGA_MODE_LOADER_TIMEOUT_EN
    chk("tmo_strobe_len", k, TMO);
    chk("tmo_error", error, 1);
    chk("tmo_done", done, 0);
`else
    chk("hold_strobe_len", k, 40);
    chk("hold_strobe_up", wb_cyc_o, 1);
    chk("hold_no_error", error, 0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    slave_mute = 1'b0;
    tick();
    chk("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_mode_loader.md
VGA_MODE_LOADER -- requirements
Module: vga_mode_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0400_0000, word address of the VGA core register block.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles to wait for wb_ack_i per write, range 2..255.
REQ-003 clk  input  1  clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to program a mode; sampled only in IDLE.
REQ-006 mode_sel  input  2  0 = blank/disable, 1 = 640x480, 2 and 3 = reserved.
REQ-007 color  input  12  {r,g,b} fill colour, 4 bits each.
REQ-008 wb_addr_o  output  32  Wishbone address.
REQ-009 wb_data_o  output  32  Wishbone write data.
REQ-010 wb_sel_o  output  4  byte select; 4'hF during a cycle, 0 otherwise.
REQ-011 wb_we_o, wb_stb_o, wb_cyc_o  output  1 each  Wishbone write strobe set; the three are always equal.
REQ-012 wb_ack_i  input  1  Wishbone acknowledge.
REQ-013 busy  output  1  high from the cycle after start is accepted until the sequence ends.
REQ-014 done  output  1  one-cycle pulse when all writes are acknowledged.
REQ-015 error  output  1  sticky until the next accepted start; set on reserved mode or timeout.

Function
REQ-016 States: IDLE, WRITE, GAP, FINISH; reset enters IDLE.
REQ-017 In IDLE with start=1, mode_sel and color are latched; later changes to these inputs have no effect on the sequence.
REQ-018 A reserved mode goes directly to FINISH with error=1 and never asserts wb_cyc_o; done is not pulsed.
REQ-019 Write order and offsets: idx0 +0x0, idx1 +0x4, idx2 +0xC, idx3 +0x8, so the enable bit is written last.
REQ-020 idx0 data = {2'b0, h_sync_start[9:0], h_sync_end[9:0], h_active_start[9:0]}.
REQ-021 idx1 data = {2'b0, v_sync_start, v_sync_end, v_active_start}.
REQ-022 idx2 data = {20'b0, color}.
REQ-023 idx3 data = {9'b0, enabled, h_pol, v_pol, h_active_end[9:0], v_active_end[9:0]}.
REQ-024 Mode 1 field values: h 656/752/0/640, v 490/492/0/480, h_pol=v_pol=enabled=1.
REQ-025 Mode 0 field values: all timing fields 0, pols 0, enabled=0; all four writes are still issued.
REQ-026 The first strobe is asserted the cycle after start is sampled.
REQ-027 In WRITE, strobe, address and data are held stable until the cycle in which wb_ack_i=1.
REQ-028 At the ack edge, the block moves to GAP and deasserts the strobe for exactly one cycle.
REQ-029 wb_ack_i is ignored in GAP and in IDLE, so a trailing ack from a registered slave is not counted.
REQ-030 After GAP, the block advances to the next idx; after idx3, it moves to FINISH.
REQ-031 FINISH lasts one cycle: done=1 unless error is set, then IDLE; busy is low in IDLE.
REQ-032 A start received while busy is ignored and not queued.
REQ-033 With a slave that acks one cycle after the strobe, the full sequence takes 12 cycles from the first strobe to done.

Reset
REQ-034 On reset: state IDLE; wb_addr_o=0, wb_data_o=0, wb_sel_o=0, we/stb/cyc=0, busy=0, done=0, error=0, idx=0, timeout counter=0.
REQ-035 A reset in the middle of a sequence drops the strobe at that same edge; no further write is issued until a new start.

Configuration
REQ-036 Macro VGA_MODE_LOADER_TIMEOUT_EN defined: a counter cleared on strobe assertion counts strobe cycles without ack.
REQ-037 With that macro defined, TIMEOUT cycles without ack deassert the strobe, set error=1 and go to FINISH; done is not pulsed.
REQ-038 Macro undefined: the block waits for ack indefinitely, no counter is built, and error is raised only by a reserved mode.

Verification
REQ-039 mode 1, color 12'hF80, slave acks after 1 cycle -> writes 0x0400_0000=0x290BC000, 0x0400_0004=0x1EA7B000, 0x0400_000C=0x00000F80, 0x0400_0008=0x007A01E0, in that order; done 12 cycles after the first strobe.
REQ-040 mode 0 -> 4 writes, word at +0x8 = 0x00000000, done=1, error=0.
REQ-041 mode 2 -> no wb_cyc_o; busy for 1 cycle, then error=1, done=0; a following mode 1 start clears error.
REQ-042 Slave holds ack high 2 cycles per strobe -> exactly 4 writes, no skipped or doubled idx.
REQ-043 TIMEOUT_EN with a slave that never acks -> strobe drops after 16 cycles, error=1; without the macro, strobe stays high.
REQ-044 Reset asserted during idx2 -> all outputs 0 at the next edge; a new start rewrites from idx0.
